// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: elastic valid/ready pipeline stage with a one-entry skid buffer.
// Latency: a word accepted at edge N is on out_data (out_valid=1) in cycle N+1; 1 word/cycle sustained.
// Backpressure: in_ready is registered; after out_ready drops one more word lands in skid, then in_ready falls.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid/in_data     upstream word offer
//   in_ready             registered accept (low only when both entries are full)
//   out_valid/out_data   registered head word
//   out_ready            downstream accept of the head word
//   flush                synchronous discard of every held word (and any same-cycle input)
//   occupancy            words held: 0, 1 or 2
module pipe_skid_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             flush,
  output logic [1:0]       occupancy
);

  // State encoding equals the word count, so occupancy is the state register itself.
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;

  logic w_in_xfer;
  logic w_out_xfer;

  // Handshake qualifiers depend only on registered state, never on out_ready directly.
  assign in_ready   = (r_state != TWO);
  assign out_valid  = (r_state != EMPTY);
  assign out_data   = r_main;
  assign occupancy  = r_state;

  assign w_in_xfer  = in_valid  && in_ready;
  assign w_out_xfer = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else if (flush) begin
      // Data registers keep stale contents; they are don't-care while out_valid is low.
      r_state <= EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_xfer) begin
            r_main  <= in_data;
            r_state <= ONE;
          end
        end
        ONE: begin
          if (w_out_xfer && w_in_xfer) begin
            r_main <= in_data;
          end else if (w_out_xfer) begin
            r_state <= EMPTY;
          end else if (w_in_xfer) begin
            // Downstream stalled this edge: park the word so in_ready can stay registered.
            r_skid  <= in_data;
            r_state <= TWO;
          end
        end
        TWO: begin
          if (w_out_xfer) begin
            r_main  <= r_skid;
            r_state <= ONE;
          end
        end
        default: begin
          r_state <= EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
module tb_pipe_skid_reg;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        flush;
  logic [1:0]  occupancy;

  int total;
  int bad;

  pipe_skid_reg #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .flush     (flush),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check the full observable state in one call.
  task automatic chk_state(input string tag, input logic vld, input logic rdy,
                           input logic [1:0] occ);
    chk({tag, "_vld"}, {31'd0, out_valid}, {31'd0, vld});
    chk({tag, "_rdy"}, {31'd0, in_ready},  {31'd0, rdy});
    chk({tag, "_occ"}, {30'd0, occupancy}, {30'd0, occ});
  endtask

  logic [31:0] q[$];
  logic [31:0] nxt;
  logic        m_in;
  logic        m_out;

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; in_valid = 1'b1; in_data = 32'h99; out_ready = 1'b1; flush = 1'b0;
    // in_valid during reset must be ignored.
    step();
    step();
    rst = 1'b0; in_valid = 1'b0;
    chk_state("reset", 1'b0, 1'b1, 2'd0);
    chk("reset_data", out_data, 32'h0);

    // Stream 1..8 back to back, each visible one cycle after acceptance.
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = i;
      step();
      chk($sformatf("stream_%0d", i), out_data, i);
      chk_state($sformatf("stream_%0d", i), 1'b1, 1'b1, 2'd1);
    end
    in_valid = 1'b0;
    step();
    chk_state("stream_end", 1'b0, 1'b1, 2'd0);

    // Stall: A0 presented, then out_ready drops; A1 lands in skid, A2 refused.
    in_valid = 1'b1; in_data = 32'hA0; out_ready = 1'b1;
    step();
    chk("stall_a0", out_data, 32'hA0);
    out_ready = 1'b0; in_data = 32'hA1;
    step();
    chk_state("stall_two", 1'b1, 1'b0, 2'd2);
    chk("stall_head", out_data, 32'hA0);
    in_data = 32'hA2;
    step();
    chk_state("stall_hold", 1'b1, 1'b0, 2'd2);
    chk("stall_hold_head", out_data, 32'hA0);
    out_ready = 1'b1;
    step();
    chk("stall_a1", out_data, 32'hA1);
    chk_state("stall_a1", 1'b1, 1'b1, 2'd1);
    step();
    chk("stall_a2", out_data, 32'hA2);
    in_valid = 1'b0;
    step();
    chk_state("stall_end", 1'b0, 1'b1, 2'd0);

    // Drain: fill 0x11,0x22 then drain with no input.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h11;
    step();
    in_data = 32'h22;
    step();
    chk_state("drain_full", 1'b1, 1'b0, 2'd2);
    chk("drain_full_head", out_data, 32'h11);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk_state("drain_one", 1'b1, 1'b1, 2'd1);
    chk("drain_one_head", out_data, 32'h22);
    step();
    chk_state("drain_empty", 1'b0, 1'b1, 2'd0);

    // Flush while holding two words, with a simultaneous input offer.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h33;
    step();
    in_data = 32'h44;
    step();
    flush = 1'b1; in_data = 32'hDEADBEEF;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk_state("flush_two", 1'b0, 1'b1, 2'd0);
    chk("flush_two_nobeef", {31'd0, out_data == 32'hDEADBEEF}, 32'd0);
    // Flush-to-accept: a new word is taken on the very next edge.
    in_valid = 1'b1; in_data = 32'h55;
    step();
    chk("flush_accept", out_data, 32'h55);
    chk_state("flush_accept", 1'b1, 1'b1, 2'd1);
    // Flush in ONE where in_ready=1: the input transfer must still be discarded.
    flush = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk_state("flush_one", 1'b0, 1'b1, 2'd0);
    step();
    chk_state("flush_one_after", 1'b0, 1'b1, 2'd0);
    chk("flush_one_nobeef", {31'd0, out_data == 32'hDEADBEEF}, 32'd0);

    // Random handshake against a queue model.
    nxt = 32'h1000;
    q.delete();
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 199) == 0);
      in_data   = nxt;
      chk("rnd_vld", {31'd0, out_valid}, {31'd0, q.size() != 0});
      chk("rnd_rdy", {31'd0, in_ready},  {31'd0, q.size() != 2});
      chk("rnd_occ", {30'd0, occupancy}, q.size());
      if (q.size() != 0) chk("rnd_data", out_data, q[0]);
      m_in  = in_valid && (q.size() != 2);
      m_out = (q.size() != 0) && out_ready;
      if (m_in) nxt = nxt + 1;
      if (flush) begin
        q.delete();
      end else begin
        if (m_out) void'(q.pop_front());
        if (m_in) q.push_back(in_data);
      end
      step();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    step();
    chk_state("rnd_end", 1'b0, 1'b1, 2'd0);

    // Reset mid-stall with an input offered: all words lost, outputs at reset values.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h66;
    step();
    in_data = 32'h77;
    step();
    chk_state("rst_stall_pre", 1'b1, 1'b0, 2'd2);
    rst = 1'b1; in_data = 32'h88;
    step();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk_state("rst_stall", 1'b0, 1'b1, 2'd0);
    chk("rst_stall_data", out_data, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_state($sformatf("rst_after_%0d", i), 1'b0, 1'b1, 2'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Elastic 32-bit pipeline stage with a valid/ready handshake on both sides and a one-entry skid buffer. It sits between two datapath stages and replaces a free-running capture register wherever the downstream stage can stall. It breaks the combinational ready path, keeps full throughput, preserves word order and supports a synchronous pipeline flush.

## Interface
- WIDTH, 32, data word width in bits.
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream word present on in_data.
- in_data  input  WIDTH  upstream word.
- in_ready  output  1  stage can accept a word this cycle; registered, never combinational from out_ready.
- out_valid  output  1  out_data holds a valid word.
- out_data  output  WIDTH  head word; registered.
- out_ready  input  1  downstream accepts the head word this cycle.
- flush  input  1  synchronous discard of all held words.
- occupancy  output  2  number of words held: 0, 1 or 2.

## Operation
- Storage: main register (drives out_data) plus one skid register. State is EMPTY (0 words), ONE (main only) or TWO (main plus skid).
- Transfer rules: an input transfer occurs when in_valid && in_ready at a rising edge. An output transfer occurs when out_valid && out_ready at a rising edge.
- EMPTY: an input transfer loads main and moves to ONE.
- ONE, output transfer with input transfer: main <= in_data; stay in ONE.
- ONE, output transfer only: go to EMPTY.
- ONE, input transfer only: skid <= in_data; go to TWO.
- ONE, no transfer: hold.
- TWO: in_ready = 0. An output transfer moves skid to main and goes to ONE. Otherwise hold.
- Derived outputs: out_valid = (state != EMPTY). in_ready = (state != TWO). occupancy = 0/1/2 for EMPTY/ONE/TWO. All are registered.
- Ordering: words leave in exactly the order they were accepted. No word is duplicated or dropped except by flush or rst.
- Flush: state goes to EMPTY at the edge. Any input transfer in the same cycle is discarded, and an output transfer in the same cycle is treated as consumed. Data registers hold their stale contents, which are don't-care while out_valid = 0.
- Priority: rst over flush, flush over handshake.
- in_data and out_ready are ignored when their respective valid/ready qualifier is low.

## Timing
- Reset values: out_valid = 0, in_ready = 1, occupancy = 0, out_data = 0, skid register = 0.
- In the rst-high cycle, in_valid is ignored. The first transfer can occur on the edge after rst deasserts.
- Latency: a word accepted at edge N appears on out_data with out_valid = 1 after edge N (visible in cycle N+1).
- Throughput: 1 word per cycle sustained while out_ready = 1.
- Backpressure: after out_ready drops, at most one more word is accepted (into skid). in_ready falls at the following edge.
- When out_ready returns in state TWO: the skid word is presented one cycle later, and in_ready rises at that same edge.
- Flush-to-accept: in_ready = 1 and out_valid = 0 in the cycle after flush. A new word can be accepted on that cycle's edge.
- Reset mid-operation: both held words are lost. Outputs take their reset values after the rst edge regardless of state.

## Test plan
- Reset then stream: hold rst 2 cycles. Send 0x00000001..0x00000008 back-to-back with out_ready = 1. Require out_data to show 1..8 on consecutive cycles, each one cycle after acceptance, with no bubbles.
- Stall: send 0xA0, 0xA1, 0xA2 continuously and drop out_ready the cycle 0xA0 is presented. Require 0xA0 and 0xA1 held (occupancy = 2), in_ready = 0, and 0xA2 not accepted. Raise out_ready: require 0xA0, 0xA1, 0xA2 in order.
- Occupancy and drain: fill to 2 (0x11, 0x22), then set out_ready = 1 with in_valid = 0. Require occupancy 2 -> 1 -> 0 on successive edges, out_valid low after 0x22 leaves, and in_ready = 1 throughout the drain after the first edge.
- Flush with simultaneous input: hold 2 words and assert flush with in_valid = 1, in_data = 0xDEADBEEF. Require occupancy = 0 and out_valid = 0 next cycle, and 0xDEADBEEF never appears on out_data.
- Random handshake: 10k cycles of random in_valid and out_ready with an incrementing data pattern. A scoreboard requires in-order, lossless delivery, with in_ready never asserted while occupancy = 2.
- Reset mid-stall: assert rst in state TWO while in_valid = 1. Require out_valid = 0, in_ready = 1, out_data = 0 after the edge, and no held or incoming word delivered later.
